// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with per-slot blanking gap.
// Optional leading-zero suppression: define SEG7_SCAN_LZ_SUPPRESS_EN.
module seg7_scan_driver #(
    parameter int unsigned N_DIGITS     = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     digit_en,
    input  logic                    load,
    output logic [0:6]              seg_out,
    output logic                    dp_out,
    output logic [N_DIGITS-1:0]     an_out
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*N_DIGITS-1:0]   val_q;
    logic [N_DIGITS-1:0]     dp_q;
    logic [N_DIGITS-1:0]     lz_sup;

    logic [N_DIGITS-1:0]     an_d;
    logic [6:0]              seg_d;
    logic                    dp_d;
    logic [3:0]              nib;

    // Hex nibble to active-low a..g pattern (a is the MSB of the returned value).
    function automatic logic [6:0] seg_code(input logic [3:0] n);
        case (n)
            4'h0: seg_code = 7'h01;
            4'h1: seg_code = 7'h4f;
            4'h2: seg_code = 7'h12;
            4'h3: seg_code = 7'h06;
            4'h4: seg_code = 7'h4c;
            4'h5: seg_code = 7'h24;
            4'h6: seg_code = 7'h20;
            4'h7: seg_code = 7'h0f;
            4'h8: seg_code = 7'h00;
            4'h9: seg_code = 7'h0c;
            4'ha: seg_code = 7'h08;
            4'hb: seg_code = 7'h60;
            4'hc: seg_code = 7'h31;
            4'hd: seg_code = 7'h42;
            4'he: seg_code = 7'h30;
            default: seg_code = 7'h38;
        endcase
    endfunction

    // Prescaler and digit index; idx steps when cnt wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_W'(SCAN_DIV - 1)) begin
            cnt <= '0;
            idx <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Shadow registers; the display never looks at the live value/dp inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= '0;
            dp_q  <= '0;
        end else if (load) begin
            val_q <= value;
            dp_q  <= dp_in;
        end
    end

`ifdef SEG7_SCAN_LZ_SUPPRESS_EN
    // A digit above 0 is dark when it and every more significant nibble is zero.
    always_comb begin
        logic zero_run;
        lz_sup   = '0;
        zero_run = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            zero_run  = zero_run & (val_q[4*k +: 4] == 4'h0);
            lz_sup[k] = zero_run;
        end
    end
`else
    assign lz_sup = '0;
`endif

    always_comb begin
        an_d  = '1;
        seg_d = 7'h7f;
        dp_d  = 1'b1;
        nib   = val_q[idx*4 +: 4];
        if (cnt >= CNT_W'(BLANK_CYCLES)) begin
            an_d[idx] = ~digit_en[idx];
            seg_d     = lz_sup[idx] ? 7'h7f : seg_code(nib);
            // A disabled digit keeps its decimal point dark as well.
            dp_d      = ~(dp_q[idx] & digit_en[idx]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_out  <= '1;
            seg_out <= 7'h7f;
            dp_out  <= 1'b1;
        end else begin
            an_out  <= an_d;
            seg_out <= seg_d;
            dp_out  <= dp_d;
        end
    end

endmodule
